ped_crossing_ctrl: RTL and testbench

//  Downstream consumer of the two-way traffic light FSM. Takes its R/Y/G lamp

---
 rtl/ped_crossing_if.sv | 23 ++
 rtl/ped_crossing_ctrl.sv | 145 ++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ped_crossing_if.sv
// Lamp buses from the traffic light FSM plus the pedestrian signal-head outputs.
interface ped_crossing_if;
  logic [1:0] R;
  logic [1:0] Y;
  logic [1:0] G;
  logic [1:0] ped_req;
  logic [1:0] walk;
  logic [1:0] dont_walk;
  logic [1:0] pending;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic       fault;

  modport master (
    output R, Y, G, ped_req,
    input  walk, dont_walk, pending, cnt0, cnt1, fault
  );

  modport slave (
    input  R, Y, G, ped_req,
    output walk, dont_walk, pending, cnt0, cnt1, fault
  );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian signal heads for two crossings, slaved to the traffic light lamp
// buses, with a sticky lamp-fault monitor that forces every crossing safe.
module ped_crossing_ctrl #(
  parameter int unsigned WALK_CYC  = 4,
  parameter int unsigned FLASH_CYC = 3,
  parameter int unsigned FLASH_DIV = 1
) (
  input  logic          clk,
  input  logic          reset,
  ped_crossing_if.slave bus
);
  localparam int unsigned NR = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WALK, FLASH} state_e;

  state_e        state_q [NR];
  state_e        state_d [NR];
  logic [CW-1:0] rem_q   [NR];
  logic [CW-1:0] rem_d   [NR];
  logic [CW-1:0] cnt_q   [NR];
  logic [CW-1:0] cnt_d   [NR];
  logic [DW-1:0] div_q   [NR];
  logic [DW-1:0] div_d   [NR];
  logic [NR-1:0] fl_q, fl_d;
  logic [NR-1:0] r_q, y_q, g_q, r_prev_q;
  logic [NR-1:0] pending_q, pending_d;
  logic [NR-1:0] walk_q, walk_d;
  logic [NR-1:0] dont_walk_q, dont_walk_d;
  logic [NR-1:0] onset;
  logic          vld_q;
  logic          fault_q, fault_d;
  logic          lamp_bad;

  assign onset = r_q & ~r_prev_q;

  // vld_q masks the all-zero lamp registers left behind by reset
  always_comb begin
    lamp_bad = (r_q == '0);
    for (int d = 0; d < NR; d++) begin
      if (!$onehot({r_q[d], y_q[d], g_q[d]})) lamp_bad = 1'b1;
    end
  end

  assign fault_d = fault_q | (vld_q & lamp_bad);

  always_comb begin
    pending_d   = pending_q | bus.ped_req;
    walk_d      = '0;
    dont_walk_d = '1;
    fl_d        = fl_q;
    for (int d = 0; d < NR; d++) begin
      state_d[d] = state_q[d];
      rem_d[d]   = rem_q[d];
      div_d[d]   = div_q[d];
      cnt_d[d]   = '0;
      case (state_q[d])
        IDLE: begin
          if (onset[d] && pending_q[d] && !fault_d) begin
            state_d[d]   = WALK;
            rem_d[d]     = CW'(WALK_CYC + FLASH_CYC);
            pending_d[d] = bus.ped_req[d];
          end
        end
        WALK: begin
          walk_d[d]      = 1'b1;
          dont_walk_d[d] = 1'b0;
          cnt_d[d]       = rem_q[d];
          rem_d[d]       = rem_q[d] - CW'(1);
          if (rem_q[d] == CW'(FLASH_CYC + 1)) begin
            state_d[d] = FLASH;
            fl_d[d]    = 1'b1;
            div_d[d]   = '0;
          end
        end
        FLASH: begin
          dont_walk_d[d] = fl_q[d];
          cnt_d[d]       = rem_q[d];
          rem_d[d]       = rem_q[d] - CW'(1);
          if (div_q[d] == DW'(FLASH_DIV - 1)) begin
            div_d[d] = '0;
            fl_d[d]  = ~fl_q[d];
          end else begin
            div_d[d] = div_q[d] + DW'(1);
          end
          if (rem_q[d] == CW'(1)) state_d[d] = IDLE;
        end
        default: state_d[d] = IDLE;
      endcase
      // Red ending early or a lamp fault overrides everything for this crossing
      if (fault_d || !r_q[d]) begin
        state_d[d]     = IDLE;
        walk_d[d]      = 1'b0;
        dont_walk_d[d] = 1'b1;
        cnt_d[d]       = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int d = 0; d < NR; d++) begin
        state_q[d] <= IDLE;
        rem_q[d]   <= '0;
        cnt_q[d]   <= '0;
        div_q[d]   <= '0;
      end
      fl_q        <= '0;
      r_q         <= '0;
      y_q         <= '0;
      g_q         <= '0;
      r_prev_q    <= '0;
      vld_q       <= 1'b0;
      pending_q   <= '0;
      walk_q      <= '0;
      dont_walk_q <= '1;
      fault_q     <= 1'b0;
    end else begin
      for (int d = 0; d < NR; d++) begin
        state_q[d] <= state_d[d];
        rem_q[d]   <= rem_d[d];
        cnt_q[d]   <= cnt_d[d];
        div_q[d]   <= div_d[d];
      end
      fl_q        <= fl_d;
      r_q         <= bus.R;
      y_q         <= bus.Y;
      g_q         <= bus.G;
      r_prev_q    <= r_q;
      vld_q       <= 1'b1;
      pending_q   <= pending_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.walk      = walk_q;
  assign bus.dont_walk = dont_walk_q;
  assign bus.pending   = pending_q;
  assign bus.cnt0      = cnt_q[0];
  assign bus.cnt1      = cnt_q[1];
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: fixed vector table, directed corner sequences and
// randomized lamp/button traffic against a timestamp-based reference model.
module tb_ped_crossing_ctrl;
  localparam int unsigned WALK_CYC  = 4;
  localparam int unsigned FLASH_CYC = 3;
  localparam int unsigned FLASH_DIV = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ped_crossing_if bus ();

  ped_crossing_ctrl #(
    .WALK_CYC (WALK_CYC),
    .FLASH_CYC(FLASH_CYC),
    .FLASH_DIV(FLASH_DIV)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a served crossing is remembered by the edge it was granted on
  logic [1:0] m_r, m_y, m_g, m_rp;
  bit         m_vld, m_fault;
  bit   [1:0] m_pend, m_busy;
  int         m_start [2];
  int         n_edge = 0;
  bit   [1:0] e_walk, e_dw, e_pend;
  bit   [3:0] e_cnt [2];
  bit         e_fault;

  function automatic bit lamps_bad(input logic [1:0] r, y, g);
    for (int d = 0; d < 2; d++)
      if ($countones({r[d], y[d], g[d]}) != 1) return 1'b1;
    return (r == 2'b00);
  endfunction

  task automatic model_step(input bit rst, input logic [1:0] r, y, g, req);
    bit f, grant;
    int k;
    n_edge++;
    if (!rst) begin
      m_r = '0; m_y = '0; m_g = '0; m_rp = '0;
      m_vld = 0; m_fault = 0; m_pend = '0; m_busy = '0;
      e_walk = '0; e_dw = 2'b11; e_pend = '0; e_cnt[0] = '0; e_cnt[1] = '0; e_fault = 0;
      return;
    end
    f = m_fault | (m_vld && lamps_bad(m_r, m_y, m_g));
    for (int d = 0; d < 2; d++) begin
      k = n_edge - 1 - m_start[d];
      e_walk[d] = 0; e_dw[d] = 1; e_cnt[d] = '0;
      if (m_busy[d] && m_r[d] && !f) begin
        if (k < int'(WALK_CYC)) begin
          e_walk[d] = 1; e_dw[d] = 0;
        end else begin
          e_dw[d] = (((k - int'(WALK_CYC)) / int'(FLASH_DIV)) % 2) == 0;
        end
        e_cnt[d] = 4'(int'(WALK_CYC + FLASH_CYC) - k);
      end
      grant = 0;
      if (f || !m_r[d]) m_busy[d] = 0;
      else if (m_busy[d]) m_busy[d] = (k + 1 < int'(WALK_CYC + FLASH_CYC));
      else if (!m_rp[d] && m_pend[d]) begin
        m_busy[d] = 1; m_start[d] = n_edge; grant = 1;
      end
      m_pend[d] = (m_pend[d] & !grant) | req[d];
    end
    m_fault = f; e_fault = f; e_pend = m_pend;
    m_rp = m_r; m_r = r; m_y = y; m_g = g; m_vld = 1;
  endtask

  task automatic tick(input bit rst, input logic [1:0] r, y, g, req);
    reset = rst; bus.R = r; bus.Y = y; bus.G = g; bus.ped_req = req;
    @(posedge clk);
    model_step(rst, r, y, g, req);
    #1;
    check("walk", bus.walk, e_walk);
    check("dont_walk", bus.dont_walk, e_dw);
    check("pending", bus.pending, e_pend);
    check("cnt0", bus.cnt0, e_cnt[0]);
    check("cnt1", bus.cnt1, e_cnt[1]);
    check("fault", bus.fault, e_fault);
  endtask

  // 16-cycle light loop: road0 green 6 / yellow 2, then road1 green 6 / yellow 2
  logic [1:0] lr, ly, lg;
  int ph = 0;
  task automatic lamps(input int p);
    ly = 2'b00; lg = 2'b00;
    if (p < 6)       begin lr = 2'b10; lg = 2'b01; end
    else if (p < 8)  begin lr = 2'b10; ly = 2'b01; end
    else if (p < 14) begin lr = 2'b01; lg = 2'b10; end
    else             begin lr = 2'b01; ly = 2'b10; end
  endtask

  int w0_cnt, w1_cnt, ovl, dw_bad;
  task automatic run(input int cyc, input logic [1:0] req0);
    w0_cnt = 0; w1_cnt = 0; ovl = 0; dw_bad = 0;
    for (int i = 0; i < cyc; i++) begin
      lamps(ph);
      tick(1'b1, lr, ly, lg, (i == 0) ? req0 : 2'b00);
      ph = (ph + 1) % 16;
      w0_cnt += int'(bus.walk[0]);
      w1_cnt += int'(bus.walk[1]);
      if (bus.walk == 2'b11) ovl++;
      if (bus.dont_walk != 2'b11) dw_bad++;
    end
  endtask

  task automatic do_reset();
    lamps(ph);
    tick(1'b0, lr, ly, lg, 2'b00);
    ph = (ph + 1) % 16;
  endtask

  typedef struct {
    int rst; int p; int req;
    int walk; int dw; int pend; int c0; int c1; int flt;
  } vec_t;
  vec_t tbl [19];

  initial begin
    logic [1:0] rq;
    // road-0 request during green, served at the next road-0 red onset
    tbl = '{
      '{0, 0, 0, 0, 3, 0, 0, 0, 0}, '{1, 0, 1, 0, 3, 1, 0, 0, 0},
      '{1, 1, 0, 0, 3, 1, 0, 0, 0}, '{1, 2, 0, 0, 3, 1, 0, 0, 0},
      '{1, 3, 0, 0, 3, 1, 0, 0, 0}, '{1, 4, 0, 0, 3, 1, 0, 0, 0},
      '{1, 5, 0, 0, 3, 1, 0, 0, 0}, '{1, 6, 0, 0, 3, 1, 0, 0, 0},
      '{1, 7, 0, 0, 3, 1, 0, 0, 0}, '{1, 8, 0, 0, 3, 1, 0, 0, 0},
      '{1, 9, 0, 0, 3, 0, 0, 0, 0}, '{1, 10, 0, 1, 2, 0, 7, 0, 0},
      '{1, 11, 0, 1, 2, 0, 6, 0, 0}, '{1, 12, 0, 1, 2, 0, 5, 0, 0},
      '{1, 13, 0, 1, 2, 0, 4, 0, 0}, '{1, 14, 0, 0, 3, 0, 3, 0, 0},
      '{1, 15, 0, 0, 2, 0, 2, 0, 0}, '{1, 0, 0, 0, 3, 0, 1, 0, 0},
      '{1, 1, 0, 0, 3, 0, 0, 0, 0}
    };
    for (int i = 0; i < 19; i++) begin
      lamps(tbl[i].p);
      tick(tbl[i].rst != 0, lr, ly, lg, 2'(tbl[i].req));
      check("tbl_walk", bus.walk, tbl[i].walk);
      check("tbl_dont_walk", bus.dont_walk, tbl[i].dw);
      check("tbl_pending", bus.pending, tbl[i].pend);
      check("tbl_cnt0", bus.cnt0, tbl[i].c0);
      check("tbl_cnt1", bus.cnt1, tbl[i].c1);
      check("tbl_fault", bus.fault, tbl[i].flt);
    end
    ph = 2;

    // road-1 press mid-red waits for the following onset
    do_reset();
    run(16 + ((3 - ph + 16) % 16), 2'b00);
    run(13, 2'b10);
    check("midred_no_walk1", w1_cnt, 0);
    run(16, 2'b00);
    check("midred_walk1_next", w1_cnt, WALK_CYC);
    check("midred_walk0_none", w0_cnt, 0);

    // both buttons: each crossing walks once, never together
    run(32, 2'b11);
    check("both_walk0", w0_cnt, WALK_CYC);
    check("both_walk1", w1_cnt, WALK_CYC);
    check("both_overlap", ovl, 0);

    // road-0 red withdrawn two cycles into walk
    run(9, 2'b01);
    run(3, 2'b00);
    ph = 0; lamps(ph);
    tick(1'b1, lr, ly, lg, 2'b00);
    check("drop_still_walk", bus.walk[0], 1);
    ph = 1; lamps(ph);
    tick(1'b1, lr, ly, lg, 2'b00);
    check("drop_walk0", bus.walk[0], 0);
    check("drop_dw0", bus.dont_walk[0], 1);
    check("drop_cnt0", bus.cnt0, 0);
    ph = 2;

    // reset pulse during flashing don't-walk
    run(6, 2'b01);
    run(7, 2'b00);
    check("flash_entry_cnt0", bus.cnt0, FLASH_CYC);
    check("flash_entry_walk0", bus.walk[0], 0);
    do_reset();
    check("rst_walk", bus.walk, 0);
    check("rst_dont_walk", bus.dont_walk, 2'b11);
    check("rst_pending", bus.pending, 0);
    check("rst_cnt0", bus.cnt0, 0);
    run(32, 2'b00);
    check("rst_no_walk0", w0_cnt, 0);
    check("rst_no_walk1", w1_cnt, 0);

    // both roads non-red for one cycle -> sticky fault
    run(4, 2'b00);
    tick(1'b1, 2'b00, 2'b00, 2'b11, 2'b00);
    check("fault_not_yet", bus.fault, 0);
    ph = (ph + 1) % 16;
    run(1, 2'b00);
    check("fault_set", bus.fault, 1);
    run(32, 2'b11);
    check("fault_no_walk", w0_cnt + w1_cnt, 0);
    check("fault_dw_safe", dw_bad, 0);
    check("fault_held", bus.fault, 1);
    check("fault_pending_latched", bus.pending, 2'b11);
    do_reset();
    check("fault_cleared", bus.fault, 0);

    // random buttons, phase jumps, glitches and resets
    for (int s = 0; s < 6; s++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 9) == 0) ph = $urandom_range(0, 15);
        lamps(ph);
        if (s >= 4 && $urandom_range(0, 39) == 0) begin
          lr = 2'($urandom); ly = 2'($urandom); lg = 2'($urandom);
        end
        rq = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        tick($urandom_range(0, 63) != 0, lr, ly, lg, rq);
        ph = (ph + 1) % 16;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
